// File: rtl/seg_readback.sv
// Seven-segment bus reader: synchronizes segment/anode lines, waits for a stable
// lit digit, decodes the glyph back to a nibble and holds it per digit position.
module seg_readback #(
    parameter int NUM_DIGITS    = 4,
    parameter int IDX_W         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    upd_pulse,
    output logic [IDX_W-1:0]        upd_idx
);

    localparam int                CNT_W    = 8;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam int                PAIR_W   = NUM_DIGITS + 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Two-flop synchronizers on both buses.
    logic [6:0]            seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NUM_DIGITS-1:0] an_s1_q,  an_s1_d,  an_s2_q,  an_s2_d;

    always_comb begin
        seg_s1_d = seg_in;
        seg_s2_d = seg_s1_q;
        an_s1_d  = an_in;
        an_s2_d  = an_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            an_s1_q  <= '0;
            an_s2_q  <= '0;
        end else begin
            seg_s1_q <= seg_s1_d;
            seg_s2_q <= seg_s2_d;
            an_s1_q  <= an_s1_d;
            an_s2_q  <= an_s2_d;
        end
    end

    // A pair is usable only when exactly one anode is driven low.
    logic                 an_qual;
    logic                 an_found;
    logic                 an_multi;
    logic [IDX_W-1:0]     an_idx;
    logic [PAIR_W-1:0]    pair_s;

    always_comb begin
        an_found = 1'b0;
        an_multi = 1'b0;
        an_idx   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an_s2_q[k]) begin
                if (an_found) begin
                    an_multi = 1'b1;
                end
                an_found = 1'b1;
                an_idx   = IDX_W'(k);
            end
        end
        an_qual = an_found && !an_multi;
        pair_s  = {an_s2_q, seg_s2_q};
    end

    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = {1'b0, 4'h0};
            7'b1111001: res = {1'b0, 4'h1};
            7'b0100100: res = {1'b0, 4'h2};
            7'b0110000: res = {1'b0, 4'h3};
            7'b0011001: res = {1'b0, 4'h4};
            7'b0010010: res = {1'b0, 4'h5};
            7'b0000010: res = {1'b0, 4'h6};
            7'b1111000: res = {1'b0, 4'h7};
            7'b0000000: res = {1'b0, 4'h8};
            7'b0010000: res = {1'b0, 4'h9};
            7'b0000110: res = {1'b0, 4'hE};
            default:    res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    logic       dec_err;
    logic [3:0] dec_val;

    always_comb begin
        {dec_err, dec_val} = decode_glyph(seg_s2_q);
    end

    // Stability tracker: counts identical qualified samples against a reference.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAIR_W-1:0] ref_q, ref_d;
    logic              commit;
    logic              upd_pulse_q, upd_pulse_d;
    logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (an_qual) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_W'(1);
                    ref_d   = pair_s;
                end
            end
            S_TRACK: begin
                if (!an_qual) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (pair_s != ref_q) begin
                    ref_d = pair_s;
                    cnt_d = CNT_W'(1);
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_MAX;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!an_qual) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (pair_s != ref_q) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_W'(1);
                    ref_d   = pair_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Clear drops any commit landing on the same edge.
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            commit  = 1'b0;
        end

        upd_pulse_d = commit;
        upd_idx_d   = commit ? an_idx : upd_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ref_q       <= '0;
            upd_pulse_q <= 1'b0;
            upd_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            upd_pulse_q <= upd_pulse_d;
            upd_idx_q   <= upd_idx_d;
        end
    end

    assign upd_pulse = upd_pulse_q;
    assign upd_idx   = upd_idx_q;

    // One holding register set per digit position.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gen_digit
            logic [3:0] dig_q, dig_d;
            logic       val_q, val_d;
            logic       err_q, err_d;
            logic       hit;

            always_comb begin
                hit   = commit && (an_idx == IDX_W'(gi));
                dig_d = dig_q;
                val_d = val_q;
                err_d = err_q;
                if (clear) begin
                    dig_d = '0;
                    val_d = 1'b0;
                    err_d = 1'b0;
                end else if (hit) begin
                    dig_d = dec_val;
                    val_d = 1'b1;
                    err_d = dec_err;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dig_q <= '0;
                    val_q <= 1'b0;
                    err_q <= 1'b0;
                end else begin
                    dig_q <= dig_d;
                    val_q <= val_d;
                    err_q <= err_d;
                end
            end

            assign digits_out[4*gi +: 4] = dig_q;
            assign valid_out[gi]         = val_q;
            assign err_out[gi]           = err_q;
        end
    endgenerate

endmodule
